multiword_add_sequencer: RTL



---
 rtl/multiword_add_sequencer_pkg.sv | 13 +
 rtl/multiword_add_sequencer_csa.sv | 36 +++
 rtl/multiword_add_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the word-serial long-operand adder/subtractor:
// sequencer state encodings and operation codes.
package multiword_add_sequencer_pkg;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_NEXT  = 1'b1
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/multiword_add_sequencer_csa.sv
// Carry-select adder: each BLOCK_SIZE slice precomputes its sum for both
// carry-in values, and the rippling block carry picks one of them.
module carry_select_adder #(
  parameter int WIDTH      = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NUM_BLK = (WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;

  logic [NUM_BLK:0] blk_c_s;

  assign blk_c_s[0] = cin;
  assign cout       = blk_c_s[NUM_BLK];

  for (genvar i = 0; i < NUM_BLK; i++) begin : g_blk
    localparam int LO = i * BLOCK_SIZE;
    localparam int BW = ((WIDTH - LO) < BLOCK_SIZE) ? (WIDTH - LO) : BLOCK_SIZE;

    logic [BW:0] r0_s;
    logic [BW:0] r1_s;

    // r1 cannot overflow: r0 is at most 2^(BW+1)-2.
    assign r0_s = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
    assign r1_s = r0_s + {{BW{1'b0}}, 1'b1};

    assign sum[LO +: BW] = blk_c_s[i] ? r1_s[BW-1:0] : r0_s[BW-1:0];
    assign blk_c_s[i+1]  = blk_c_s[i] ? r1_s[BW]     : r0_s[BW];
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Word-serial long-operand adder/subtractor: LS word first, inter-word carry
// held locally, one registered result word per accepted input word.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_r;
  state_e           state_nxt_s;
  logic             carry_r;
  logic             sub_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_word_s;
  logic             accept_s;
  logic             sub_s;
  logic             cin_s;
  logic             cout_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] sum_s;

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;

  // Operation select, adder carry-in, word count and next state.
  always_comb begin
    sub_s       = in_sub;
    cin_s       = in_sub;
    cnt_word_s  = CNT_ONE;
    state_nxt_s = state_r;
    case (state_r)
      ST_FIRST: begin
        sub_s      = in_sub;
        cin_s      = in_sub;
        cnt_word_s = CNT_ONE;
        if (accept_s && !in_last) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_FIRST;
        end
      end
      ST_NEXT: begin
        sub_s = sub_r;
        cin_s = carry_r;
        if (cnt_r == CNT_MAX) begin
          cnt_word_s = cnt_r;
        end else begin
          cnt_word_s = cnt_r + CNT_ONE;
        end
        if (accept_s && in_last) begin
          state_nxt_s = ST_FIRST;
        end else begin
          state_nxt_s = ST_NEXT;
        end
      end
      default: begin
        state_nxt_s = ST_FIRST;
      end
    endcase
    if (sub_s == OP_SUB) begin
      b_eff_s = ~in_b;
    end else begin
      b_eff_s = in_b;
    end
  end

  carry_select_adder #(
    .WIDTH      (WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_adder (
    .a    (in_a),
    .b    (b_eff_s),
    .cin  (cin_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Inter-word carry, operation, word counter and output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
      out_sum   <= {WIDTH{1'b0}};
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_count <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      carry_r   <= cout_s;
      sub_r     <= (state_r == ST_FIRST) ? in_sub : sub_r;
      out_valid <= 1'b1;
      out_sum   <= sum_s;
      out_last  <= in_last;
      if (in_last) begin
        // A subtract reports borrow, the inverse of the adder carry.
        out_carry <= sub_s ^ cout_s;
        out_count <= cnt_word_s;
        cnt_r     <= {CNT_W{1'b0}};
      end else begin
        out_carry <= 1'b0;
        out_count <= {CNT_W{1'b0}};
        cnt_r     <= cnt_word_s;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
